// File: rtl/sap_bus_pkg.sv
// Shared definitions for the SAP bus hub: source indices, default widths
// and the occupancy-counter width helper.
package sap_bus_pkg;

   // Fixed driver slots on the shared bus; lower index wins arbitration.
   localparam int SRC_REG   = 0;
   localparam int SRC_MEM   = 1;
   localparam int SRC_ALU   = 2;
   localparam int SRC_FLAGS = 3;

   localparam int DEF_BUS_W = 16;
   localparam int DEF_OUT_W = 8;

   // Bits needed to hold an occupancy value from 0 up to and including depth.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/bus_io_hub_disp_fifo.sv
// First-word-fall-through display FIFO with a sticky overflow flag.
// A push while full is only taken when the head is popped in the same cycle.
module disp_fifo
   import sap_bus_pkg::*;
#(
   parameter int OUT_W = DEF_OUT_W,
   parameter int DEPTH = 4
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      err_clr,
   input  logic                      wr_en,
   input  logic [OUT_W-1:0]          wr_data,
   output logic                      full,
   output logic [cnt_w(DEPTH)-1:0]   count,
   output logic                      ovf,
   output logic [OUT_W-1:0]          rd_data,
   output logic                      rd_valid,
   input  logic                      rd_ready
);

   localparam int CNT_W = cnt_w(DEPTH);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [OUT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count_q;
   logic             ovf_q;
   logic             push;
   logic             pop;
   logic             drop;

   assign full     = (count_q == CNT_W'(DEPTH));
   assign rd_valid = (count_q != '0);
   assign pop      = rd_valid & rd_ready;
   assign push     = wr_en & (~full | pop);
   assign drop     = wr_en & full & ~pop;
   assign count    = count_q;
   assign ovf      = ovf_q;
   // Head is read straight from storage; it only changes on a pop or on a
   // write into the head slot, so it stays stable while the FIFO is empty.
   assign rd_data  = mem[rd_ptr];

   // Storage write; data is never reset, only the control around it.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   // Pointers and occupancy; pointers wrap explicitly so DEPTH need not be a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Sticky overflow: a dropped push sets it, err_clr clears it, set wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          ovf_q <= 1'b0;
      else if (drop)    ovf_q <= 1'b1;
      else if (err_clr) ovf_q <= 1'b0;
   end

endmodule

// File: rtl/bus_io_hub.sv
// Bus/IO hub: fixed-priority merge of the datapath drivers onto one bus,
// contention detection with a sticky error, optional idle-value hold, and
// the display FIFO towards the external pins.
module bus_io_hub
   import sap_bus_pkg::*;
#(
   parameter int NUM_SRC   = 4,
   parameter int BUS_W     = DEF_BUS_W,
   parameter int OUT_W     = DEF_OUT_W,
   parameter int DEPTH     = 4,
   parameter int HOLD_MODE = 0
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_SRC-1:0]         src_oe,
   input  logic [NUM_SRC*BUS_W-1:0]   src_data,
   output logic [BUS_W-1:0]           bus,
   output logic                       bus_driven,
   output logic                       contention,
   input  logic                       err_clr,
   output logic                       bus_err,
   input  logic                       disp_we,
   input  logic [OUT_W-1:0]           disp_data,
   output logic                       disp_full,
   output logic [cnt_w(DEPTH)-1:0]    disp_count,
   output logic                       disp_ovf,
   output logic [OUT_W-1:0]           out_data,
   output logic                       out_valid,
   input  logic                       out_ready
);

   logic [BUS_W-1:0] sel_data;
   logic [BUS_W-1:0] idle_val;
   logic             bus_err_q;

   // Priority select: scan from the lowest-priority source up so index 0 ends up winning.
   always_comb begin
      sel_data = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (src_oe[i]) sel_data = src_data[i*BUS_W +: BUS_W];
      end
   end

   assign bus_driven = |src_oe;
   assign contention = ($countones(src_oe) > 1);
   assign bus        = bus_driven ? sel_data : idle_val;
   assign bus_err    = bus_err_q;

   generate
      if (HOLD_MODE == 1) begin : g_hold
         logic [BUS_W-1:0] hold_reg;
         // Remember the last driven value so an idle bus keeps presenting it.
         always_ff @(posedge clk or posedge rst) begin
            if (rst)             hold_reg <= '0;
            else if (bus_driven) hold_reg <= sel_data;
         end
         assign idle_val = hold_reg;
      end else begin : g_no_hold
         assign idle_val = '0;
      end
   endgenerate

   // Sticky contention flag: any contended edge sets it, err_clr clears it, set wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)             bus_err_q <= 1'b0;
      else if (contention) bus_err_q <= 1'b1;
      else if (err_clr)    bus_err_q <= 1'b0;
   end

   disp_fifo #(
      .OUT_W (OUT_W),
      .DEPTH (DEPTH)
   ) u_disp_fifo (
      .clk      (clk),
      .rst      (rst),
      .err_clr  (err_clr),
      .wr_en    (disp_we),
      .wr_data  (disp_data),
      .full     (disp_full),
      .count    (disp_count),
      .ovf      (disp_ovf),
      .rd_data  (out_data),
      .rd_valid (out_valid),
      .rd_ready (out_ready)
   );

endmodule

// File: doc/bus_io_hub.md
Name: bus_io_hub

Overview:
- Parametrised successor to the hard-wired SAP-3 bus priority mux and single-register display port.
- Merges NUM_SRC output-enabled drivers onto one BUS_W bus with fixed priority, detects drive contention, and optionally holds the last driven value.
- Replaces the single display register with a DEPTH-entry display FIFO using a valid/ready handshake to the external output.
- Sits in the top level, between datapath units (reg_file, memory, alu) and the controller/external pins.

Parameters:
- NUM_SRC, 4, number of bus drivers; index 0 has highest priority.
- BUS_W, 16, bus width in bits.
- OUT_W, 8, display data width.
- DEPTH, 4, display FIFO entries; must be at least 1; need not be a power of two.
- HOLD_MODE, 0, idle-bus value: 0 drives zero, 1 drives the last driven value.

Ports:
- clk  in  1  system clock (gated CPU clock); reset rst is asynchronous, active-high; clock clk.
- rst  in  1  asynchronous active-high reset.
- src_oe  in  NUM_SRC  per-source output enable.
- src_data  in  NUM_SRC*BUS_W  packed source data; source i occupies bits [i*BUS_W +: BUS_W].
- bus  out  BUS_W  resolved bus value.
- bus_driven  out  1  high when any src_oe bit is high.
- contention  out  1  high when two or more src_oe bits are high (combinational).
- err_clr  in  1  clears the sticky error flags.
- bus_err  out  1  sticky contention flag.
- disp_we  in  1  push request from the controller.
- disp_data  in  OUT_W  value to push.
- disp_full  out  1  FIFO full.
- disp_count  out  $clog2(DEPTH+1)  current occupancy.
- disp_ovf  out  1  sticky flag: a push was dropped.
- out_data  out  OUT_W  FIFO head.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts the head.

Behaviour:
- Bus resolution (combinational):
  - bus = src_data of the lowest-index source whose src_oe is set.
  - With no source enabled: zero when HOLD_MODE=0; the hold register when HOLD_MODE=1.
- Hold register: on each clk edge with bus_driven high, it loads the resolved bus. It is only present when HOLD_MODE=1.
- contention = popcount(src_oe) > 1. The resolved value still follows priority.
- bus_err: set on any clk edge where contention is high; cleared by err_clr. If set and clear occur in the same cycle, set wins.
- FIFO is first-word-fall-through:
  - out_valid = (count != 0).
  - out_data = entry at the read pointer; undefined content allowed when out_valid is low, but it must be stable.
- pop = out_valid & out_ready.
- push = disp_we & (!disp_full | pop).
  - Pushing while full is accepted only when a pop occurs in the same cycle.
- Push-to-visible latency is 1 clk. There is no bypass: with the FIFO empty, a push is visible as out_valid on the next cycle.
- Pointers wrap explicitly from DEPTH-1 to 0, and count is updated by +push -pop.
- Overflow: disp_we & disp_full & !pop drops the data, leaves FIFO contents and count unchanged, and sets disp_ovf. disp_ovf is cleared by err_clr, with set winning over clear.
- disp_full = (count == DEPTH).
- Reset (asynchronous, any time, including mid-push):
  - count, pointers, hold register, bus_err and disp_ovf go to 0.
  - out_valid = 0, disp_full = 0, disp_count = 0.
  - bus = 0 when no source is enabled.
- All state updates occur on the rising edge of clk.

Decomposition:
- Shared package sap_bus_pkg:
  - source index constants SRC_REG=0, SRC_MEM=1, SRC_ALU=2, SRC_FLAGS=3;
  - default BUS_W and OUT_W;
  - a clog2-based count-width helper.
- One sub-module, disp_fifo: parametrised OUT_W/DEPTH FWFT FIFO with pointers, count, and overflow flag.
- bus_io_hub instantiates disp_fifo and contains the priority mux, contention logic, and hold register.

Test Plan:
- Priority: src_oe=0110 with src1=0x1111 and src2=0x2222 -> bus=0x1111, contention=1, and bus_err=1 after the edge. Then err_clr -> bus_err=0.
- Idle bus: HOLD_MODE=1, drive src3=0x00A5 for one cycle, then src_oe=0 -> bus stays 0x00A5. With HOLD_MODE=0 the same stimulus -> bus=0x0000.
- FIFO fill: DEPTH=4, out_ready=0, push 0x11, 0x22, 0x33, 0x44 -> disp_full=1, disp_count=4. A fifth push of 0x55 -> dropped and disp_ovf=1. Then drain with out_ready=1 -> 0x11, 0x22, 0x33, 0x44 in order, then out_valid=0.
- Full simultaneous push/pop: FIFO full, disp_we=1 with 0x66 and out_ready=1 -> 0x11 popped, 0x66 accepted, count stays 4, disp_ovf unchanged.
- Wrap and latency: DEPTH=3, repeat push-1/pop-1 for 10 cycles with incrementing data -> each value appears exactly 1 cycle after its push, with no loss across pointer wrap.
- Reset mid-operation: with count=2 and bus_err=1, assert rst asynchronously between edges -> out_valid=0, disp_count=0, bus_err=0, disp_ovf=0, hold register=0 immediately.
